// File: rtl/branch_ctrl.sv
// Decode-stage branch resolution sequencer: waits for operands, drives the
// shared comparator from registered operands and issues a registered redirect.
module branch_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             br_valid,
    input  logic [2:0]       br_op,
    input  logic [31:0]      pc_d,
    input  logic [15:0]      imm16,
    input  logic [31:0]      rs_val,
    input  logic [31:0]      rt_val,
    input  logic             rs_ready,
    input  logic             rt_ready,
    input  logic             flush,
    output logic [31:0]      cmp_a,
    output logic [31:0]      cmp_b,
    input  logic [1:0]       cmp_pd,
    output logic             stall,
    output logic             done,
    output logic             taken,
    output logic [31:0]      target,
    output logic             illegal,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [1:0] {IDLE, WAIT, CMP} state_t;

    state_t      state, state_nx;
    logic [2:0]  op_q;
    logic [31:0] pc_q;
    logic [15:0] imm_q;
    logic [31:0] a_q, b_q;
    logic [2:0]  op_sel;
    logic        accept;
    logic        opnd_ok;
    logic        load;
    logic        resolve;
    logic        rule;
    logic        dec;
    logic [31:0] tgt;

    // In IDLE the incoming op decides readiness, afterwards the latched one.
    assign op_sel  = (state == IDLE) ? br_op : op_q;
    assign accept  = br_valid & ~flush;
    assign resolve = (state == CMP) & ~flush;

    always_comb begin
        opnd_ok = rs_ready;
        case (op_sel)
            3'd0, 3'd1: opnd_ok = rs_ready & rt_ready;
            3'd6, 3'd7: opnd_ok = 1'b1;
            default:    opnd_ok = rs_ready;
        endcase
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (opnd_ok) begin
                        load     = 1'b1;
                        state_nx = CMP;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (flush) begin
                    state_nx = IDLE;
                end else if (opnd_ok) begin
                    load     = 1'b1;
                    state_nx = CMP;
                end
            end
            CMP:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        rule = 1'b0;
        case (op_q)
            3'd0:    rule = (cmp_pd == 2'd1);
            3'd1:    rule = (cmp_pd != 2'd1);
            3'd2:    rule = (cmp_pd != 2'd2);
            3'd3:    rule = (cmp_pd == 2'd2);
            3'd4:    rule = (cmp_pd == 2'd0);
            3'd5:    rule = (cmp_pd != 2'd0);
            default: rule = 1'b0;
        endcase
    end

    // An invalid comparator code (3) only lets the unconditional branch through.
    assign dec = (op_q == 3'd6) | (rule & (cmp_pd != 2'd3));
    assign tgt = pc_q + 32'd4 + {{14{imm_q[15]}}, imm_q, 2'b00};

    assign stall = ~reset & ((state == IDLE & accept) | (state != IDLE));
    assign cmp_a = a_q;
    assign cmp_b = b_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            op_q      <= 3'd0;
            pc_q      <= 32'd0;
            imm_q     <= 16'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            done      <= 1'b0;
            taken     <= 1'b0;
            illegal   <= 1'b0;
            target    <= 32'd0;
            br_cnt    <= '0;
            taken_cnt <= '0;
        end else begin
            state   <= state_nx;
            done    <= resolve;
            taken   <= resolve & dec;
            illegal <= resolve & (op_q == 3'd7);
            if (state == IDLE && accept) begin
                op_q  <= br_op;
                pc_q  <= pc_d;
                imm_q <= imm16;
            end
            if (load) begin
                a_q <= rs_val;
                b_q <= (op_sel < 3'd2) ? rt_val : 32'd0;
            end
            if (resolve) begin
                target <= tgt;
                br_cnt <= br_cnt + CNT_W'(1);
                if (dec) begin
                    taken_cnt <= taken_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// Randomized bench for branch_ctrl against a transaction-level branch model.
module tb_branch_ctrl;

    logic        clk = 1'b0;
    logic        reset, br_valid, rs_ready, rt_ready, flush, pd3;
    logic [2:0]  br_op;
    logic [31:0] pc_d, rs_val, rt_val;
    logic [15:0] imm16;
    logic [31:0] cmp_a, cmp_b, target, s_cmp_a, s_cmp_b, s_target;
    logic [1:0]  cmp_pd, s_cmp_pd;
    logic        stall, done, taken, illegal;
    logic        s_stall, s_done, s_taken, s_illegal;
    logic [15:0] br_cnt, taken_cnt;
    logic [3:0]  s_br_cnt, s_taken_cnt;

    int checks = 0;
    int errors = 0;
    int unsigned br_n = 0;
    int unsigned tk_n = 0;
    logic [31:0] last_tgt = 32'd0;

    always #5 clk = ~clk;

    branch_ctrl u_dut (
        .clk(clk), .reset(reset), .br_valid(br_valid), .br_op(br_op),
        .pc_d(pc_d), .imm16(imm16), .rs_val(rs_val), .rt_val(rt_val),
        .rs_ready(rs_ready), .rt_ready(rt_ready), .flush(flush),
        .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_pd(cmp_pd), .stall(stall),
        .done(done), .taken(taken), .target(target), .illegal(illegal),
        .br_cnt(br_cnt), .taken_cnt(taken_cnt)
    );

    // Narrow-counter copy so wrap-around is exercised in a short run.
    branch_ctrl #(.CNT_W(4)) u_small (
        .clk(clk), .reset(reset), .br_valid(br_valid), .br_op(br_op),
        .pc_d(pc_d), .imm16(imm16), .rs_val(rs_val), .rt_val(rt_val),
        .rs_ready(rs_ready), .rt_ready(rt_ready), .flush(flush),
        .cmp_a(s_cmp_a), .cmp_b(s_cmp_b), .cmp_pd(s_cmp_pd), .stall(s_stall),
        .done(s_done), .taken(s_taken), .target(s_target), .illegal(s_illegal),
        .br_cnt(s_br_cnt), .taken_cnt(s_taken_cnt)
    );

    function automatic logic [1:0] cmp3(logic [31:0] a, logic [31:0] b, logic f);
        if (f) return 2'd3;
        if ($signed(a) < $signed(b)) return 2'd0;
        if (a == b) return 2'd1;
        return 2'd2;
    endfunction

    assign cmp_pd   = cmp3(cmp_a, cmp_b, pd3);
    assign s_cmp_pd = cmp3(s_cmp_a, s_cmp_b, pd3);

    function automatic logic model_taken(logic [2:0] op, logic [31:0] a,
                                         logic [31:0] b, logic f);
        if (op == 3'd6) return 1'b1;
        if (f) return 1'b0;
        case (op)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd2:    return $signed(a) <= $signed(b);
            3'd3:    return $signed(a) > $signed(b);
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_tgt(logic [31:0] pc, logic [15:0] imm);
        int off;
        off = int'($signed(imm));
        return pc + 32'd4 + 32'(off * 4);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_cnt();
        chk("br_cnt", 32'(br_cnt), 32'(br_n[15:0]));
        chk("taken_cnt", 32'(taken_cnt), 32'(tk_n[15:0]));
        chk("br_cnt_w4", 32'(s_br_cnt), 32'(br_n[3:0]));
        chk("taken_cnt_w4", 32'(s_taken_cnt), 32'(tk_n[3:0]));
    endtask

    task automatic idle_inputs();
        br_valid = 1'b0;
        flush    = 1'b0;
        reset    = 1'b0;
        pd3      = 1'b0;
        rs_ready = 1'b0;
        rt_ready = 1'b0;
    endtask

    // One branch; abort_kind 0 = flush, 1 = reset, applied in cycle abort_cyc.
    task automatic do_br(input logic [2:0] op, input logic [31:0] pc,
                         input logic [15:0] imm, input logic [31:0] rs,
                         input logic [31:0] rt, input int rs_w, input int rt_w,
                         input logic f, input int abort_cyc, input int abort_kind);
        int need, dcyc;
        logic [31:0] ea, eb;
        logic et;
        need = (op < 3'd2) ? ((rs_w > rt_w) ? rs_w : rt_w) :
               (op < 3'd6) ? rs_w : 0;
        dcyc = need + 2;
        ea = 32'd0;
        eb = 32'd0;
        for (int c = 0; c <= dcyc; c++) begin
            br_valid = (c == 0);
            br_op    = op;
            pc_d     = pc;
            imm16    = imm;
            pd3      = f;
            rs_ready = (c >= rs_w);
            rt_ready = (c >= rt_w);
            rs_val   = (c >= rs_w && c <= need) ? rs : rs ^ 32'h5a5a_0f0f;
            rt_val   = (c >= rt_w && c <= need) ? rt : rt - 32'd2;
            flush    = (c == abort_cyc) && (abort_kind == 0);
            reset    = (c == abort_cyc) && (abort_kind == 1);
            if (c == need) begin
                ea = rs_val;
                eb = (op < 3'd2) ? rt_val : 32'd0;
            end
            @(negedge clk);
            if (c == 0) begin
                chk("target_hold", target, last_tgt);
                chk("taken_pulse", 32'(taken), 32'd0);
                chk("illegal_pulse", 32'(illegal), 32'd0);
            end
            if (c == abort_cyc) begin
                chk("abort_stall", 32'(stall), (abort_kind == 1) ? 32'd0 : 32'd1);
                chk("abort_done", 32'(done), 32'd0);
                if (abort_kind == 1) begin
                    br_n = 0;
                    tk_n = 0;
                    last_tgt = 32'd0;
                end
                @(posedge clk);
                #1;
                for (int k = 0; k < 2; k++) begin
                    idle_inputs();
                    @(negedge clk);
                    chk("post_abort_stall", 32'(stall), 32'd0);
                    chk("post_abort_done", 32'(done), 32'd0);
                    chk_cnt();
                    @(posedge clk);
                    #1;
                end
                return;
            end
            chk("stall", 32'(stall), 32'(c < dcyc));
            chk("done", 32'(done), 32'(c == dcyc));
            if (c == dcyc - 1) begin
                chk("cmp_a", cmp_a, ea);
                chk("cmp_b", cmp_b, eb);
            end
            if (c == dcyc) begin
                et = model_taken(op, ea, eb, f);
                last_tgt = model_tgt(pc, imm);
                br_n++;
                if (et) tk_n++;
                chk("taken", 32'(taken), 32'(et));
                chk("target", target, last_tgt);
                chk("illegal", 32'(illegal), 32'(op == 3'd7));
                chk_cnt();
            end
            @(posedge clk);
            #1;
        end
        idle_inputs();
    endtask

    logic [31:0] pool [5];

    initial begin
        idle_inputs();
        br_op  = 3'd6;
        pc_d   = 32'd0;
        imm16  = 16'd0;
        rs_val = 32'd0;
        rt_val = 32'd0;
        reset  = 1'b1;
        br_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_target", target, 32'd0);
        chk("reset_cmp_a", cmp_a, 32'd0);
        chk("reset_cmp_b", cmp_b, 32'd0);
        chk_cnt();
        @(posedge clk);
        #1;
        idle_inputs();
        @(posedge clk);
        #1;

        do_br(3'd0, 32'h3000, 16'h0003, 32'd5, 32'd5, 0, 0, 1'b0, 1, 1);
        do_br(3'd0, 32'h3000, 16'h0003, 32'd5, 32'd5, 0, 0, 1'b0, -1, 0);
        do_br(3'd4, 32'h3000, 16'hFFFF, 32'hFFFF_FFFF, 32'd0, 0, 0, 1'b0, -1, 0);
        do_br(3'd5, 32'h3000, 16'hFFFF, 32'hFFFF_FFFF, 32'd0, 0, 0, 1'b0, -1, 0);
        do_br(3'd1, 32'h4000, 16'h0010, 32'd9, 32'd9, 0, 3, 1'b0, -1, 0);
        do_br(3'd2, 32'h4100, 16'h0001, 32'd0, 32'd4, 0, 5, 1'b0, -1, 0);
        do_br(3'd3, 32'h4200, 16'h0001, 32'd0, 32'd4, 0, 5, 1'b0, -1, 0);
        do_br(3'd1, 32'h4300, 16'h0002, 32'd1, 32'd2, 0, 3, 1'b0, 2, 0);
        do_br(3'd0, 32'h4400, 16'h0002, 32'd1, 32'd1, 0, 0, 1'b0, 1, 0);
        do_br(3'd7, 32'h4500, 16'h8000, 32'd1, 32'd1, 0, 0, 1'b0, -1, 0);
        do_br(3'd1, 32'h4600, 16'h0004, 32'd1, 32'd2, 0, 0, 1'b1, -1, 0);

        br_valid = 1'b1;
        flush    = 1'b1;
        br_op    = 3'd6;
        @(negedge clk);
        chk("flush_idle_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        chk("flush_idle_next", 32'(stall), 32'd0);
        chk("flush_idle_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;

        pc_d  = 32'h0000_0100;
        imm16 = 16'h0002;
        for (int c = 0; c <= 20; c++) begin
            br_valid = (c < 20);
            br_op    = 3'd6;
            @(negedge clk);
            chk("b2b_stall", 32'(stall), 32'(c < 20));
            chk("b2b_done", 32'(done), 32'(c >= 2 && c % 2 == 0));
            if (c >= 2 && c % 2 == 0) begin
                br_n++;
                tk_n++;
                last_tgt = 32'h0000_010C;
                chk("b2b_taken", 32'(taken), 32'd1);
                chk("b2b_target", target, last_tgt);
                chk_cnt();
            end
            @(posedge clk);
            #1;
        end
        idle_inputs();
        @(posedge clk);
        #1;

        pool[0] = 32'd0;
        pool[1] = 32'd1;
        pool[2] = 32'hFFFF_FFFF;
        pool[3] = 32'h8000_0000;
        for (int i = 0; i < 400; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            int rw, tw, ab;
            op = 3'($urandom_range(0, 7));
            pool[4] = $urandom;
            a  = pool[$urandom_range(0, 4)];
            b  = ($urandom_range(0, 2) == 0) ? a : pool[$urandom_range(0, 4)];
            rw = $urandom_range(0, 3);
            tw = $urandom_range(0, 3);
            ab = ($urandom_range(0, 15) == 0) ? 1 : -1;
            do_br(op, $urandom, 16'($urandom), a, b, rw, tw,
                  ($urandom_range(0, 7) == 0), ab, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Multi-cycle branch resolution sequencer for the decode stage. It accepts one conditional branch at a time and waits, with a stall, until both source operands are ready. It then drives the signed three-way comparator (pd: 0 = A<B, 1 = A==B, 2 = A>B) from registered operands and issues a one-cycle registered redirect carrying the taken flag and target. It also keeps wrap-around branch and taken counters for the performance readout.

## Interface
- CNT_W, 16, width of br_cnt / taken_cnt
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; overrides every other input
- br_valid  input  1  branch instruction present in D
- br_op  input  3  0 beq, 1 bne, 2 blez, 3 bgtz, 4 bltz, 5 bgez, 6 b (always), 7 reserved
- pc_d  input  32  PC of the branch
- imm16  input  16  branch offset, in words
- rs_val, rt_val  input  32  operand values from the forwarding muxes
- rs_ready, rt_ready  input  1  operand valid (no pending producer)
- flush  input  1  abort of the in-flight branch (exception / eret)
- cmp_a, cmp_b  output  32  to comparator A/B (registered)
- cmp_pd  input  2  comparator result
- stall  output  1  freeze PC/F/D (combinational)
- done  output  1  one-cycle resolution pulse (registered)
- taken  output  1  valid with done (registered)
- target  output  32  valid with done (registered)
- illegal  output  1  one-cycle pulse with done when br_op==7
- br_cnt, taken_cnt  output  CNT_W  resolved / taken branch counts

## Operation
- States: IDLE, WAIT, CMP.
- **IDLE**
  - Accept when br_valid & !flush.
  - On accept, latch op_q, pc_q, imm_q.
  - Operands needed: rs for every op. rt only for ops 0/1; for ops 2-7, B is forced to 0 and rt_ready is ignored.
  - Op 6 and op 7 need no operands; treat them as ready.
  - If the needed operands are ready, load a_q=rs_val and b_q=(op<2 ? rt_val : 0), then go to CMP. Otherwise go to WAIT.
- **WAIT**
  - Each cycle, re-check readiness.
  - When ready, load a_q/b_q from the current rs_val/rt_val, then go to CMP.
  - flush returns the block to IDLE.
- **CMP**
  - cmp_a=a_q, cmp_b=b_q.
  - Decision from cmp_pd:
    - beq: pd==1
    - bne: pd!=1
    - blez: pd!=2
    - bgtz: pd==2
    - bltz: pd==0
    - bgez: pd!=0
    - b: 1
    - reserved: 0
  - A pd value of 3 gives not-taken for every op except b.
  - target = pc_q + 4 + (sext(imm_q) << 2), modulo 2^32. It is computed regardless of the decision.
  - At the clock edge:
    - register done=1, taken, target, and illegal=(op_q==7);
    - increment br_cnt; increment taken_cnt if taken;
    - go to IDLE.
  - flush in CMP: go to IDLE, no done, no counter update.
- stall = !reset & ((state==IDLE & br_valid & !flush) | state==WAIT | state==CMP).
- done, taken and illegal are high for exactly one cycle. target holds its value until the next done.
- Counters wrap from all-ones to 0.

## Timing
- Reset values: state IDLE; done, taken and illegal 0; target 0; cmp_a/cmp_b 0; both counters 0; stall 0 while reset is high.
- Latency with operands ready at acceptance:
  - branch presented cycle 0 (stall=1);
  - CMP in cycle 1 (stall=1);
  - done/redirect in cycle 2 (stall=0).
- Each cycle spent in WAIT adds one cycle of latency.
- The done cycle is an IDLE cycle. A br_valid in that cycle is accepted normally, so back-to-back branches resolve every 2 cycles.
- Operands are sampled only on the transition into CMP. Changes to rs_val/rt_val afterwards are ignored.
- reset mid-operation (WAIT or CMP): next state is IDLE, no done.
- flush together with br_valid in IDLE: not accepted, stall=0.

## Test plan
- Ready beq:
  - Stimulus: rs=5, rt=5, pc_d=0x3000, imm16=0x0003, ready at cycle 0.
  - Required response: stall high in cycles 0-1; done in cycle 2 with taken=1, target=0x3010; br_cnt=1, taken_cnt=1.
- Negative offset:
  - Stimulus: bltz with rs=0xFFFFFFFF, imm16=0xFFFF, pc_d=0x3000.
  - Required response: taken=1, target=0x3000.
  - Repeat with bgez: taken=0, taken_cnt unchanged.
- Operand hazard:
  - Stimulus: bne with rt_ready low for 3 cycles, rt changing from 7 to 9 while rs=9.
  - Required response: stall for 5 cycles; done in cycle 5 with taken=0 (final rt=9 was used).
- Single-operand ops ignore rt:
  - Stimulus: blez/bgtz with rs=0 and rt_ready=0.
  - Required response: no WAIT; blez taken=1, bgtz taken=0.
- Flush and reset:
  - Stimulus: flush during WAIT; separately, reset during CMP.
  - Required response: both return to IDLE, no done, counters unchanged.
  - Stimulus: op 7.
  - Required response: done with taken=0, illegal=1.
- Counter wrap and back-to-back:
  - Stimulus: preload br_cnt to 0xFFFF (issue 65535 b branches), then issue one more; in a separate run, present branches every done cycle.
  - Required response: br_cnt wraps to 0; done pulses every 2 cycles.
